// File: rtl/store_pkg.sv
// Shared definitions for the store alignment buffer: size encodings,
// default buffer depth and the FIFO entry layout.
package store_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   localparam int DEPTH_DEFAULT = 2;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } store_entry_t;

   localparam store_entry_t ENTRY_ZERO = '{addr: 30'h0, wdata: 32'h0, be: 4'h0};

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: replicates store data into byte lanes and
// builds byte enables, flagging any access that is not naturally aligned.
module store_lane_align
   import store_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misaligned
);

   // Lane replication and enable generation by access size
   always_comb begin
      wdata      = 32'h0000_0000;
      be         = 4'b0000;
      misaligned = 1'b0;
      case (size)
         SIZE_BYTE: begin
            wdata = {4{data[7:0]}};
            be    = 4'b0001 << addr_lo;
         end
         SIZE_HALF: begin
            if (addr_lo[0] == 1'b0) begin
               wdata = {2{data[15:0]}};
               be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end else begin
               misaligned = 1'b1;
            end
         end
         SIZE_WORD: begin
            if (addr_lo == 2'b00) begin
               wdata = data;
               be    = 4'b1111;
            end else begin
               misaligned = 1'b1;
            end
         end
         default: begin
            // reserved size encoding is rejected like a misaligned access
            misaligned = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer: aligns incoming stores into word writes and queues them in a
// small FIFO toward data memory; misaligned requests are dropped with a pulse.
module store_align_buffer
   import store_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_addr,
   input  logic [31:0]              in_data,
   input  logic [1:0]               in_size,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [29:0]              out_addr,
   output logic [31:0]              out_wdata,
   output logic [3:0]               out_be,
   output logic                     misalign_err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   store_entry_t   mem_r [DEPTH];
   logic [PW-1:0]  wr_ptr_r;
   logic [PW-1:0]  rd_ptr_r;
   logic [CW-1:0]  count_r;
   logic           err_r;

   logic [31:0]    al_wdata_s;
   logic [3:0]     al_be_s;
   logic           misaligned_s;
   logic           accept_s;
   logic           push_s;
   logic           pop_s;
   store_entry_t   head_s;

   store_lane_align u_align (
      .addr_lo    (in_addr[1:0]),
      .size       (in_size),
      .data       (in_data),
      .wdata      (al_wdata_s),
      .be         (al_be_s),
      .misaligned (misaligned_s)
   );

   // in_ready depends only on occupancy so the memory side never gates intake combinationally
   assign in_ready = (count_r < DEPTH_C);
   assign accept_s = in_valid && in_ready;
   assign push_s   = accept_s && !misaligned_s;
   assign pop_s    = (count_r != {CW{1'b0}}) && out_ready;
   assign head_s   = mem_r[rd_ptr_r];

   // Pointer, occupancy and error-pulse state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         err_r    <= 1'b0;
      end else begin
         err_r <= accept_s && misaligned_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; cleared on reset so stale contents can never reach memory
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= ENTRY_ZERO;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= '{addr: in_addr[31:2], wdata: al_wdata_s, be: al_be_s};
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   assign out_valid    = (count_r != {CW{1'b0}});
   assign misalign_err = err_r;
   assign count        = count_r;

   // Head of queue is presented only while occupied, otherwise all zero
   always_comb begin
      if (out_valid) begin
         out_addr  = head_s.addr;
         out_wdata = head_s.wdata;
         out_be    = head_s.be;
      end else begin
         out_addr  = 30'h0;
         out_wdata = 32'h0;
         out_be    = 4'h0;
      end
   end

endmodule
